// File: rtl/hp_manager.sv
// Hit-point manager for a two-player round-based game.
// Tracks both players' HP from the upstream win/lose verdict, pulses HIT on each
// applied decrement, and latches the result in GAME_OVER until RESTART or RST.
// Optional feature: define HP_DRAW_DAMAGE_EN so that a draw verdict damages both players.
module hp_manager #(
    parameter logic [3:0] HP_INIT = 4'd5,
    parameter logic [3:0] DAMAGE  = 4'd1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] WL_IN,
    input  logic       RESTART,
    output logic [3:0] MY_HP,
    output logic [3:0] EN_HP,
    output logic [1:0] HIT,
    output logic       GAME_END,
    output logic [1:0] RESULT
);

    localparam logic [0:0] ST_PLAY      = 1'b0;
    localparam logic [0:0] ST_GAME_OVER = 1'b1;

    localparam logic [1:0] WL_NONE  = 2'b00;
    localparam logic [1:0] WL_SELF  = 2'b01;
    localparam logic [1:0] WL_ENEMY = 2'b10;
    localparam logic [1:0] WL_DRAW  = 2'b11;

    logic [0:0] state_q, state_d;
    logic [1:0] wl_prev_q;
    logic [3:0] my_hp_q, my_hp_d;
    logic [3:0] en_hp_q, en_hp_d;
    logic [1:0] hit_q, hit_d;
    logic [1:0] result_q, result_d;

    logic       draw_dmg;
    logic       verdict_ev;
    logic       dmg_en;
    logic       dmg_my;

`ifdef HP_DRAW_DAMAGE_EN
    assign draw_dmg = 1'b1;
`else
    assign draw_dmg = 1'b0;
`endif

    // A verdict held over several cycles counts once; a direct change between
    // two non-zero codes is a fresh event.
    assign verdict_ev = (WL_IN != WL_NONE) && (WL_IN != wl_prev_q);
    assign dmg_en     = verdict_ev && ((WL_IN == WL_SELF)  || ((WL_IN == WL_DRAW) && draw_dmg));
    assign dmg_my     = verdict_ev && ((WL_IN == WL_ENEMY) || ((WL_IN == WL_DRAW) && draw_dmg));

    // Saturating subtraction of DAMAGE.
    function automatic logic [3:0] sat_sub(input logic [3:0] hp);
        sat_sub = (hp > DAMAGE) ? (hp - DAMAGE) : 4'd0;
    endfunction

    // Next-state logic: apply damage in PLAY, wait for RESTART in GAME_OVER.
    always_comb begin
        state_d  = state_q;
        my_hp_d  = my_hp_q;
        en_hp_d  = en_hp_q;
        hit_d    = 2'b00;
        result_d = result_q;
        if (state_q == ST_PLAY) begin
            if (dmg_en || dmg_my) begin
                if (dmg_my) begin
                    my_hp_d = sat_sub(my_hp_q);
                end
                if (dmg_en) begin
                    en_hp_d = sat_sub(en_hp_q);
                end
                hit_d = {dmg_my, dmg_en};
                // KO is decided on the same edge as the decrement.
                if ((my_hp_d == 4'd0) || (en_hp_d == 4'd0)) begin
                    state_d  = ST_GAME_OVER;
                    result_d = {my_hp_d == 4'd0, en_hp_d == 4'd0};
                end
            end
        end else begin
            // Verdicts are ignored here, including one arriving with RESTART.
            if (RESTART) begin
                state_d  = ST_PLAY;
                my_hp_d  = HP_INIT;
                en_hp_d  = HP_INIT;
                result_d = 2'b00;
            end
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_PLAY;
            wl_prev_q <= WL_NONE;
            my_hp_q   <= HP_INIT;
            en_hp_q   <= HP_INIT;
            hit_q     <= 2'b00;
            result_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            wl_prev_q <= WL_IN;
            my_hp_q   <= my_hp_d;
            en_hp_q   <= en_hp_d;
            hit_q     <= hit_d;
            result_q  <= result_d;
        end
    end

    assign MY_HP    = my_hp_q;
    assign EN_HP    = en_hp_q;
    assign HIT      = hit_q;
    assign GAME_END = (state_q == ST_GAME_OVER);
    assign RESULT   = result_q;

endmodule

// File: tb/tb_hp_manager.sv
// Self-checking bench for hp_manager: directed vector table followed by
// randomized verdict streams compared against a rule-level game model.
module tb_hp_manager;

    localparam int INIT = 5;
    localparam int DMG  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] wl_in = 2'b00;
    logic       restart = 1'b0;
    logic [3:0] my_hp;
    logic [3:0] en_hp;
    logic [1:0] hit;
    logic       game_end;
    logic [1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    hp_manager #(
        .HP_INIT (4'd5),
        .DAMAGE  (4'd1)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .WL_IN    (wl_in),
        .RESTART  (restart),
        .MY_HP    (my_hp),
        .EN_HP    (en_hp),
        .HIT      (hit),
        .GAME_END (game_end),
        .RESULT   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] wl;
        logic       rs;
        int         my;
        int         en;
        int         hit;
        int         ge;
        int         res;
    } vec_t;

    vec_t vecs[$];

    // Game model: HP as plain integers, previous verdict remembered as a number.
    int m_my, m_en, m_prev, m_hit, m_res;
    bit m_over;

    task automatic add(input logic r, input logic [1:0] w, input logic s,
                       input int my, input int en, input int h, input int ge, input int res);
        vec_t v;
        v.rst = r; v.wl = w; v.rs = s;
        v.my = my; v.en = en; v.hit = h; v.ge = ge; v.res = res;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dec(input int hp);
        return (hp - DMG < 0) ? 0 : hp - DMG;
    endfunction

    task automatic model_step(input bit r, input int w, input bit s);
        bit ev, hurt_me, hurt_en, draw_hurts;
`ifdef HP_DRAW_DAMAGE_EN
        draw_hurts = 1'b1;
`else
        draw_hurts = 1'b0;
`endif
        if (r) begin
            m_over = 0; m_my = INIT; m_en = INIT; m_prev = 0; m_hit = 0; m_res = 0;
            return;
        end
        ev = (w != 0) && (w != m_prev);
        m_hit = 0;
        if (!m_over) begin
            hurt_en = ev && (w == 1 || (w == 3 && draw_hurts));
            hurt_me = ev && (w == 2 || (w == 3 && draw_hurts));
            if (hurt_en) m_en = dec(m_en);
            if (hurt_me) m_my = dec(m_my);
            m_hit = (hurt_me ? 2 : 0) + (hurt_en ? 1 : 0);
            if ((hurt_en || hurt_me) && (m_my == 0 || m_en == 0)) begin
                m_over = 1;
                m_res  = (m_my == 0 ? 2 : 0) + (m_en == 0 ? 1 : 0);
            end
        end else if (s) begin
            m_over = 0; m_my = INIT; m_en = INIT; m_res = 0;
        end
        m_prev = w;
    endtask

    // Drive one cycle of inputs, clock it, and advance the model alongside.
    task automatic step(input logic r, input logic [1:0] w, input logic s);
        rst = r; wl_in = w; restart = s;
        @(posedge clk);
        #1;
        model_step(r, int'(w), s);
    endtask

    initial begin
        // Reset and a held self-win verdict.
        add(1, 0, 0, 5, 5, 0, 0, 0);
        add(0, 1, 0, 5, 4, 1, 0, 0);
        add(0, 1, 0, 5, 4, 0, 0, 0);
        add(0, 1, 0, 5, 4, 0, 0, 0);
        add(0, 1, 0, 5, 4, 0, 0, 0);
        add(0, 0, 0, 5, 4, 0, 0, 0);
        add(0, 2, 0, 4, 4, 2, 0, 0);
        add(0, 0, 0, 4, 4, 0, 0, 0);
        // Back-to-back 01,10,00.
        add(0, 1, 0, 4, 3, 1, 0, 0);
        add(0, 2, 0, 3, 3, 2, 0, 0);
        add(0, 0, 0, 3, 3, 0, 0, 0);
        // RESTART in PLAY does nothing.
        add(0, 0, 1, 3, 3, 0, 0, 0);
        add(0, 2, 0, 2, 3, 2, 0, 0);
        add(0, 0, 0, 2, 3, 0, 0, 0);
        // Reset mid-game with MY_HP=2.
        add(1, 0, 0, 5, 5, 0, 0, 0);
        // Five separated enemy wins.
        add(0, 2, 0, 4, 5, 2, 0, 0);
        add(0, 0, 0, 4, 5, 0, 0, 0);
        add(0, 2, 0, 3, 5, 2, 0, 0);
        add(0, 0, 0, 3, 5, 0, 0, 0);
        add(0, 2, 0, 2, 5, 2, 0, 0);
        add(0, 0, 0, 2, 5, 0, 0, 0);
        add(0, 2, 0, 1, 5, 2, 0, 0);
        add(0, 0, 0, 1, 5, 0, 0, 0);
        add(0, 2, 0, 0, 5, 2, 1, 2);
        add(0, 0, 0, 0, 5, 0, 1, 2);
        add(0, 2, 0, 0, 5, 0, 1, 2);
        // RESTART together with a fresh 01 event.
        add(0, 1, 1, 5, 5, 0, 0, 0);
        add(0, 1, 0, 5, 5, 0, 0, 0);
        add(0, 0, 0, 5, 5, 0, 0, 0);
        // Alternate direct changes down to 1/1.
        add(0, 1, 0, 5, 4, 1, 0, 0);
        add(0, 2, 0, 4, 4, 2, 0, 0);
        add(0, 1, 0, 4, 3, 1, 0, 0);
        add(0, 2, 0, 3, 3, 2, 0, 0);
        add(0, 1, 0, 3, 2, 1, 0, 0);
        add(0, 2, 0, 2, 2, 2, 0, 0);
        add(0, 1, 0, 2, 1, 1, 0, 0);
        add(0, 2, 0, 1, 1, 2, 0, 0);
`ifdef HP_DRAW_DAMAGE_EN
        add(0, 3, 0, 0, 0, 3, 1, 3);
        add(0, 1, 0, 0, 0, 0, 1, 3);
`else
        add(0, 3, 0, 1, 1, 0, 0, 0);
        add(0, 3, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1, 1);
`endif
        // Reset out of GAME_OVER.
        add(1, 0, 0, 5, 5, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wl, vecs[i].rs);
            chk($sformatf("vec%0d MY_HP", i), int'(my_hp), vecs[i].my);
            chk($sformatf("vec%0d EN_HP", i), int'(en_hp), vecs[i].en);
            chk($sformatf("vec%0d HIT", i), int'(hit), vecs[i].hit);
            chk($sformatf("vec%0d GAME_END", i), int'(game_end), vecs[i].ge);
            chk($sformatf("vec%0d RESULT", i), int'(result), vecs[i].res);
        end

        // Random verdict streams against the model.
        for (int c = 0; c < 3000; c++) begin
            logic       r, s;
            logic [1:0] w;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 5) == 0);
            w = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : wl_in;
            step(r, w, s);
            chk($sformatf("rnd%0d MY_HP", c), int'(my_hp), m_my);
            chk($sformatf("rnd%0d EN_HP", c), int'(en_hp), m_en);
            chk($sformatf("rnd%0d HIT", c), int'(hit), m_hit);
            chk($sformatf("rnd%0d GAME_END", c), int'(game_end), int'(m_over));
            chk($sformatf("rnd%0d RESULT", c), int'(result), m_res);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hp_manager.md
HP_MANAGER -- requirements
Module: hp_manager

Interface
REQ-001 Parameter HP_INIT, default 4'd5: starting HP for both players.
REQ-002 Parameter DAMAGE, default 4'd1: HP removed per lost round.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 WL_IN  input  2  round verdict from the upstream win/lose stage: 00 none, 01 self win, 10 enemy win, 11 draw.
REQ-006 RESTART  input  1  level; starts a new game from GAME_OVER.
REQ-007 MY_HP  output  4  own HP, registered.
REQ-008 EN_HP  output  4  enemy HP, registered.
REQ-009 HIT  output  2  one-cycle pulse, registered: bit0 enemy damaged, bit1 self damaged.
REQ-010 GAME_END  output  1  high while in GAME_OVER.
REQ-011 RESULT  output  2  00 undecided, 01 self won, 10 enemy won, 11 both KO; held until restart or reset.

Function
REQ-012 The FSM SHALL have two states, PLAY and GAME_OVER; encoding is free.
REQ-013 Register WL_PREV SHALL capture WL_IN every cycle in all states.
REQ-014 A verdict event SHALL be defined as WL_IN != 00 and WL_IN != WL_PREV; a verdict held for N cycles is exactly one event.
REQ-015 A direct change of WL_IN between two non-zero codes (e.g. 01->10) SHALL be a new event.
REQ-016 In PLAY, an event 01 SHALL reduce EN_HP by DAMAGE, and event 10 SHALL reduce MY_HP by DAMAGE, on the same edge that samples the event.
REQ-017 Event 11 SHALL be handled per REQ-030/REQ-031.
REQ-018 Subtraction SHALL saturate at 0; no wrap-around.
REQ-019 HIT SHALL be high for exactly the cycle after an applied decrement, reflecting which HP was reduced, else 00.
REQ-020 On the edge where a decrement makes MY_HP or EN_HP 0, the FSM SHALL enter GAME_OVER on that same edge.
REQ-021 RESULT SHALL then be 01 if only EN_HP is 0, 10 if only MY_HP is 0, and 11 if both are 0.
REQ-022 In GAME_OVER, events SHALL be ignored: HP held, HIT=00.
REQ-023 RESTART=1 in GAME_OVER SHALL, on the next edge, enter PLAY, load both HPs with HP_INIT, and clear RESULT to 00.
REQ-024 An event in the same cycle as RESTART SHALL be ignored.
REQ-025 RESTART in PLAY SHALL be ignored.
REQ-026 HP_INIT of 0 SHALL be unsupported; DAMAGE >= HP_INIT SHALL give a one-round KO.

Reset
REQ-027 RST SHALL take priority over all inputs.
REQ-028 On reset: state PLAY, MY_HP=EN_HP=HP_INIT, WL_PREV=00, HIT=00, GAME_END=0, RESULT=00.
REQ-029 Reset asserted mid-game or in GAME_OVER SHALL abandon the game with no HIT pulse.

Configuration
REQ-030 With macro HP_DRAW_DAMAGE_EN defined, event 11 SHALL reduce both HPs by DAMAGE with HIT=11, and a double KO SHALL give RESULT=11.
REQ-031 Without HP_DRAW_DAMAGE_EN, event 11 SHALL update WL_PREV only: no HP change, HIT=00, and RESULT=11 SHALL be unreachable.

Verification
REQ-032 Reset, then WL_IN=01 held 4 cycles -> EN_HP 5->4 once, single HIT=01 pulse, MY_HP=5.
REQ-033 Five separated 10 events (00 between) -> MY_HP reaches 0 on the 5th; GAME_END=1 and RESULT=10 on the same edge; a further 10 leaves MY_HP=0.
REQ-034 WL_IN sequence 01,10,00 with no gap -> EN_HP=4, MY_HP=4, HIT 01 then 10.
REQ-035 HP_DRAW_DAMAGE_EN defined, both HP=1, event 11 -> both 0, HIT=11, RESULT=11. Macro undefined -> HP unchanged, HIT=00.
REQ-036 GAME_OVER with RESTART=1 and WL_IN=01 in the same cycle -> PLAY, both HP=5, RESULT=00, no HIT; RST mid-game with MY_HP=2 -> MY_HP=5 next cycle.
